complex_hadamard4: RTL and testbench
====================================

// Module: complex_hadamard4
// PURPOSE
//  4-point complex Hadamard (radix-4 DFT butterfly) with per-lane twiddle multiply, on a
//  9-bit mini-float format (1 sign, 4 exp, 4 mantissa). Core stage of the FFT datapath.
//  Floats are converted to fixed point, combined, twiddled, re-normalised, and emitted
//  with a one-cycle done pulse.
// PARAMETERS
//  expWidth     4   exponent bits, bias 2^(expWidth-1)-1 = 7
//  sigWidth     4   stored mantissa bits, hidden leading 1
//  formatWidth  9   float width = 1+expWidth+sigWidth
//  fixWidth     21  internal signed fixed width, Q10.10 (1 sign, 10 int, 10 frac)
// PORTS
//  clk                in   1    clock, all state on posedge
//  rst                in   1    reset; asynchronous, active-low
//  start              in   1    level request; a 0->1 transition while idle launches a job
//  input_real         in   36   lane k = bits[9k+8:9k], real part of x_k
//  input_imag         in   36   lane k = imag part of x_k
//  twiddle_real       in   36   lane k = real part of twiddle for output k
//  twiddle_imag       in   36   lane k = imag part of twiddle for output k
//  twiddle_real_flag  in   4    bit k=1: twiddle_real lane k is exactly 0 (value ignored)
//  twiddle_imag_flag  in   4    bit k=1: twiddle_imag lane k is exactly 0 (value ignored)
//  output_real        out  36   lane k = real part of y_k
//  output_imag        out  36   lane k = imag part of y_k
//  hadamard_done      out  1    one-cycle pulse, outputs valid from this cycle
// BEHAVIOUR
//  Format: value=(-1)^s*1.m*2^(e-7); e=0 => zero (no subnormals, -0 reads as 0).
//  Launch: start_q registered; launch when start & ~start_q & idle. Edges while busy ignored;
//   start held high across several edges launches once. Inputs/twiddles sampled at launch.
//  Pipeline, FSM IDLE->CONV->BFLY->TWID->NORM->IDLE, one cycle each:
//   CONV: 8 inputs + 8 twiddles float->Q10.10 (exact; fixed lsb 2^-10).
//   BFLY: y0=a+b+c+d, y1=a-jb-c+jd, y2=a-b+c-d, y3=a+jb-c-jd (a=x0..d=x3), saturate to fixWidth.
//   TWID: y_k*=w_k complex; products >>10, sum saturated to fixWidth.
//   NORM: fixed->float, sign-magnitude; round to nearest, ties away from zero, on 4 mant bits;
//    carry renormalises exponent; |v|<2^-6 after rounding => +0 (9'b0);
//    |v|>max (1.9375*2^8) => saturate to s_1111_1111.
//  Latency: launch edge N -> hadamard_done high and outputs updated at edge N+4.
//  Outputs registered, held until the next job completes. Reset: all outputs 0, FSM IDLE,
//   start_q 0; reset mid-job aborts it with no done pulse.
// STRUCTURE
//  Package: FP_BIAS=7, FRAC_BITS=10, FP_MAX magnitude, state enum.
//  Sub-module fp2fix (float->fixed); fixed->float NORM logic inline or as fix2fp.
// TESTING  (twiddle all lanes 0_0111_0000 =1.0, imag flags 4'b1111 unless stated)
//  x real=imag={x3,x2,x1,x0}={1_1100_1000,0_1000_1000,1_0111_1111,1_1100_1000} ->
//   y0 re/im 1_1101_1000; y1 re 1_1001_0100 im 1_1101_1000;
//   y2 re/im 0_1001_0100; y3 re 1_1101_1000 im 1_1001_0100; done 4 cycles after edge.
//  start held high 2 cycles -> exactly one done pulse; second edge during busy ignored.
//  all inputs 0 -> all outputs 9'b0; all x=0_1111_1111, twiddle 1 -> y0 saturates 0_1111_1111.
//  twiddle lane1 real flag=1, imag 0_0111_0000 (=j) -> y1 equals j*(untwiddled y1).
//  rst low mid-job -> outputs 0, no done; next start edge works normally.

Source files
------------

// File: rtl/complex_hadamard4_pkg.sv
// complex_hadamard4_pkg: mini-float/fixed-point constants, types and saturation helpers
package complex_hadamard4_pkg;
  localparam int EXP_W = 4;
  localparam int SIG_W = 4;
  localparam int FMT_W = 1 + EXP_W + SIG_W;
  localparam int FIX_W = 21;
  localparam int ACC_W = 48;
  localparam int LANES = 4;
  localparam int FP_BIAS = 7;
  localparam int FRAC_BITS = 10;
  localparam logic [FMT_W-2:0] FP_MAX = '1;
  typedef logic signed [FIX_W-1:0] fix_t;
  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic [FMT_W-1:0] fp_t;
  typedef enum logic [2:0] {IDLE, CONV, BFLY, TWID, NORM} state_t;
  function automatic acc_t ext(input fix_t v);
    return acc_t'(v);
  endfunction
  function automatic fix_t sat_fix(input acc_t v);
    fix_t hi, lo;
    hi = {1'b0, {(FIX_W-1){1'b1}}};
    lo = {1'b1, {(FIX_W-1){1'b0}}};
    return v > ext(hi) ? hi : v < ext(lo) ? lo : v[FIX_W-1:0];
  endfunction
endpackage

// File: rtl/complex_hadamard4_fix2fp.sv
// complex_hadamard4_fix2fp: Q10.10 to mini-float, round half away from zero, flush and saturate
module complex_hadamard4_fix2fp
  import complex_hadamard4_pkg::*;
(
  input  fix_t x,
  output fp_t  f
);
  logic [FIX_W-1:0] mag;
  logic [4:0] p;
  logic [5:0] sh;
  logic [5:0] r;
  logic [5:0] e;
  // find the leading one, keep hidden+4 mantissa+round bits, round, then clamp the exponent range
  always_comb begin
    mag = x[FIX_W-1] ? -x : x;
    p = '0;
    for (int i = 0; i < FIX_W; i++) if (mag[i]) p = 5'(i);
    sh = 6'({mag, 1'b0} >> (p - 5'd4));
    r = 6'(({1'b0, sh} + 7'd1) >> 1);
    e = 6'(p) + 6'(r[5:4]) + 6'(FP_BIAS - FRAC_BITS - 1);
    f = p < 5'd4 ? '0 : e > 6'd15 ? {x[FIX_W-1], FP_MAX} : {x[FIX_W-1], e[3:0], r[3:0]};
  end
endmodule

// File: rtl/complex_hadamard4_fp2fix.sv
// complex_hadamard4_fp2fix: exact mini-float to signed Q10.10 conversion, zero flag forces 0
module complex_hadamard4_fp2fix
  import complex_hadamard4_pkg::*;
(
  input  fp_t  f,
  input  logic zero,
  output fix_t x
);
  logic [EXP_W-1:0] e;
  logic [FIX_W-1:0] mag;
  assign e = f[FMT_W-2:SIG_W];
  assign mag = FIX_W'({1'b1, f[SIG_W-1:0]}) << (e - EXP_W'(FP_BIAS + SIG_W - FRAC_BITS));
  assign x = (zero || e == '0) ? '0 : f[FMT_W-1] ? -fix_t'(mag) : fix_t'(mag);
endmodule

// File: rtl/complex_hadamard4.sv
// complex_hadamard4: radix-4 complex butterfly with per-lane twiddle multiply on 9-bit mini-floats
module complex_hadamard4
  import complex_hadamard4_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [LANES*FMT_W-1:0] input_real,
  input  logic [LANES*FMT_W-1:0] input_imag,
  input  logic [LANES*FMT_W-1:0] twiddle_real,
  input  logic [LANES*FMT_W-1:0] twiddle_imag,
  input  logic [LANES-1:0]       twiddle_real_flag,
  input  logic [LANES-1:0]       twiddle_imag_flag,
  output logic [LANES*FMT_W-1:0] output_real,
  output logic [LANES*FMT_W-1:0] output_imag,
  output logic                   hadamard_done
);
  state_t state, state_d;
  logic start_q, launch;
  logic [LANES*FMT_W-1:0] in_re, in_im, tw_re, tw_im, nr, ni;
  logic [LANES-1:0] fr, fi;
  fix_t cxr [LANES], cxi [LANES], cwr [LANES], cwi [LANES];
  fix_t xr [LANES], xi [LANES], wr [LANES], wi [LANES];
  fix_t byr [LANES], byi [LANES], yr [LANES], yi [LANES];
  fix_t tzr [LANES], tzi [LANES], zr [LANES], zi [LANES];
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    complex_hadamard4_fp2fix u_xr (.f(in_re[FMT_W*i +: FMT_W]), .zero(1'b0), .x(cxr[i]));
    complex_hadamard4_fp2fix u_xi (.f(in_im[FMT_W*i +: FMT_W]), .zero(1'b0), .x(cxi[i]));
    complex_hadamard4_fp2fix u_wr (.f(tw_re[FMT_W*i +: FMT_W]), .zero(fr[i]), .x(cwr[i]));
    complex_hadamard4_fp2fix u_wi (.f(tw_im[FMT_W*i +: FMT_W]), .zero(fi[i]), .x(cwi[i]));
    complex_hadamard4_fix2fp u_nr (.x(zr[i]), .f(nr[FMT_W*i +: FMT_W]));
    complex_hadamard4_fix2fp u_ni (.x(zi[i]), .f(ni[FMT_W*i +: FMT_W]));
  end
  // launch on a rising start while idle, then walk one stage per cycle back to idle
  always_comb begin
    launch = start & ~start_q & (state == IDLE);
    state_d = state == IDLE ? (launch ? CONV : IDLE) :
              state == CONV ? BFLY :
              state == BFLY ? TWID :
              state == TWID ? NORM : IDLE;
  end
  // radix-4 butterfly; multiplying by -j maps (re, im) to (im, -re)
  always_comb begin
    byr[0] = sat_fix(ext(xr[0]) + ext(xr[1]) + ext(xr[2]) + ext(xr[3]));
    byi[0] = sat_fix(ext(xi[0]) + ext(xi[1]) + ext(xi[2]) + ext(xi[3]));
    byr[1] = sat_fix(ext(xr[0]) + ext(xi[1]) - ext(xr[2]) - ext(xi[3]));
    byi[1] = sat_fix(ext(xi[0]) - ext(xr[1]) - ext(xi[2]) + ext(xr[3]));
    byr[2] = sat_fix(ext(xr[0]) - ext(xr[1]) + ext(xr[2]) - ext(xr[3]));
    byi[2] = sat_fix(ext(xi[0]) - ext(xi[1]) + ext(xi[2]) - ext(xi[3]));
    byr[3] = sat_fix(ext(xr[0]) - ext(xi[1]) - ext(xr[2]) + ext(xi[3]));
    byi[3] = sat_fix(ext(xi[0]) + ext(xr[1]) - ext(xi[2]) - ext(xr[3]));
  end
  // complex twiddle multiply; each product is rescaled to Q10.10 before the sum is saturated
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      tzr[k] = sat_fix(((ext(yr[k]) * ext(wr[k])) >>> FRAC_BITS) - ((ext(yi[k]) * ext(wi[k])) >>> FRAC_BITS));
      tzi[k] = sat_fix(((ext(yr[k]) * ext(wi[k])) >>> FRAC_BITS) + ((ext(yi[k]) * ext(wr[k])) >>> FRAC_BITS));
    end
  end
  // control state and registered outputs; reset aborts any job in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      start_q <= 1'b0;
      output_real <= '0;
      output_imag <= '0;
      hadamard_done <= 1'b0;
    end else begin
      state <= state_d;
      start_q <= start;
      hadamard_done <= state == NORM;
      if (state == NORM) begin
        output_real <= nr;
        output_imag <= ni;
      end
    end
  end
  // pipeline data registers, each loaded only in its own stage
  always_ff @(posedge clk) begin
    if (launch) begin
      in_re <= input_real;
      in_im <= input_imag;
      tw_re <= twiddle_real;
      tw_im <= twiddle_imag;
      fr <= twiddle_real_flag;
      fi <= twiddle_imag_flag;
    end
    if (state == CONV) begin
      xr <= cxr;
      xi <= cxi;
      wr <= cwr;
      wi <= cwi;
    end
    if (state == BFLY) begin
      yr <= byr;
      yi <= byi;
    end
    if (state == TWID) begin
      zr <= tzr;
      zi <= tzi;
    end
  end
endmodule

// File: tb/tb_complex_hadamard4.sv
// tb_complex_hadamard4: scoreboard bench for the mini-float radix-4 butterfly
module tb_complex_hadamard4;
  typedef struct {
    logic [35:0] re;
    logic [35:0] im;
    int cyc;
  } exp_t;
  localparam logic [35:0] ONE4 = {4{9'b0_0111_0000}};
  localparam logic [35:0] XV = {9'b1_1100_1000, 9'b0_1000_1000, 9'b1_0111_1111, 9'b1_1100_1000};
  localparam logic [35:0] ERE = {9'b1_1101_1000, 9'b0_1001_0100, 9'b1_1001_0100, 9'b1_1101_1000};
  localparam logic [35:0] EIM = {9'b1_1001_0100, 9'b0_1001_0100, 9'b1_1101_1000, 9'b1_1101_1000};
  localparam logic [35:0] JRE = {9'b1_1101_1000, 9'b0_1001_0100, 9'b0_1101_1000, 9'b1_1101_1000};
  localparam logic [35:0] JIM = {9'b1_1001_0100, 9'b0_1001_0100, 9'b1_1001_0100, 9'b1_1101_1000};
  localparam logic [35:0] SAT = {27'b0, 9'b0_1111_1111};
  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [35:0] input_real = '0, input_imag = '0, twiddle_real = '0, twiddle_imag = '0;
  logic [3:0] twiddle_real_flag = '0, twiddle_imag_flag = '0;
  logic [35:0] output_real, output_imag, last_re = '0;
  logic hadamard_done, due;
  exp_t sb [$];
  exp_t mon_e;
  int cyc = 0, n_cmp = 0, n_err = 0;

  complex_hadamard4 dut (
    .clk(clk), .rst(rst), .start(start),
    .input_real(input_real), .input_imag(input_imag),
    .twiddle_real(twiddle_real), .twiddle_imag(twiddle_imag),
    .twiddle_real_flag(twiddle_real_flag), .twiddle_imag_flag(twiddle_imag_flag),
    .output_real(output_real), .output_imag(output_imag), .hadamard_done(hadamard_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int f2i(input logic [8:0] f);
    int mag;
    if (f[7:4] == 4'd0) return 0;
    mag = (16 + int'(f[3:0])) * (1 << (int'(f[7:4]) - 1));
    return f[8] ? -mag : mag;
  endfunction

  function automatic int sat(input longint v);
    return v > 1048575 ? 1048575 : v < -1048576 ? -1048576 : int'(v);
  endfunction

  function automatic logic [8:0] i2f(input int v);
    int mag, ulp, q, e;
    mag = v < 0 ? -v : v;
    if (mag < 16) return 9'b0;
    e = 1;
    ulp = 1;
    while (mag >= 32 * ulp) begin
      e++;
      ulp *= 2;
    end
    q = (mag + ulp / 2) / ulp;
    if (q == 32) begin
      e++;
      q = 16;
    end
    if (e > 15) return {v < 0, 8'hFF};
    return {v < 0, 4'(e), 4'(q - 16)};
  endfunction

  function automatic exp_t model(input logic [35:0] xr, xi, wr, wi, input logic [3:0] fr, fi);
    int cr [4];
    int ci [4];
    exp_t r;
    longint sr, si;
    int yr, yi, w_r, w_i, m, ar, ai;
    cr = '{1, 0, -1, 0};
    ci = '{0, -1, 0, 1};
    r.cyc = 0;
    for (int k = 0; k < 4; k++) begin
      sr = 0;
      si = 0;
      for (int n = 0; n < 4; n++) begin
        m = (n * k) % 4;
        ar = f2i(xr[9*n +: 9]);
        ai = f2i(xi[9*n +: 9]);
        sr += longint'(ar * cr[m] - ai * ci[m]);
        si += longint'(ar * ci[m] + ai * cr[m]);
      end
      yr = sat(sr);
      yi = sat(si);
      w_r = fr[k] ? 0 : f2i(wr[9*k +: 9]);
      w_i = fi[k] ? 0 : f2i(wi[9*k +: 9]);
      r.re[9*k +: 9] = i2f(sat(((longint'(yr) * w_r) >>> 10) - ((longint'(yi) * w_i) >>> 10)));
      r.im[9*k +: 9] = i2f(sat(((longint'(yr) * w_i) >>> 10) + ((longint'(yi) * w_r) >>> 10)));
    end
    return r;
  endfunction

  task automatic drive(input logic [35:0] xr, xi, wr, wi, input logic [3:0] fr, fi,
                       input bit given, input logic [35:0] ere, eim);
    exp_t e;
    if (given) begin
      e.re = ere;
      e.im = eim;
    end else e = model(xr, xi, wr, wi, fr, fi);
    @(negedge clk);
    {input_real, input_imag, twiddle_real, twiddle_imag} = {xr, xi, wr, wi};
    {twiddle_real_flag, twiddle_imag_flag} = {fr, fi};
    start = 1'b1;
    e.cyc = cyc + 5;
    sb.push_back(e);
  endtask

  task automatic job(input logic [35:0] xr, xi, wr, wi, input logic [3:0] fr, fi,
                     input bit given, input logic [35:0] ere, eim);
    drive(xr, xi, wr, wi, fr, fi, given, ere, eim);
    @(negedge clk);
    start = 1'b0;
    input_real = 36'({$urandom, $urandom});
    input_imag = 36'({$urandom, $urandom});
    twiddle_real_flag = 4'($urandom);
    repeat (5) @(negedge clk);
    check("hold_real", output_real, last_re);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      due = sb.size() > 0 && sb[0].cyc == cyc;
      check("done", 36'(hadamard_done), 36'(due));
      if (due) begin
        mon_e = sb.pop_front();
        last_re = mon_e.re;
        if (hadamard_done) begin
          check("real", output_real, mon_e.re);
          check("imag", output_imag, mon_e.im);
        end
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_real", output_real, '0);
    check("rst_imag", output_imag, '0);
    check("rst_done", 36'(hadamard_done), '0);
    rst = 1'b1;
    job(XV, XV, ONE4, 36'h1_2345_6789, 4'b0000, 4'b1111, 1'b1, ERE, EIM);
    job('0, '0, ONE4, '0, 4'b0000, 4'b1111, 1'b1, '0, '0);
    job({4{9'h0FF}}, {4{9'h0FF}}, ONE4, '0, 4'b0000, 4'b1111, 1'b1, SAT, SAT);
    job(XV, XV, ONE4, {9'h0, 9'h0, 9'b0_0111_0000, 9'h0}, 4'b0010, 4'b1101, 1'b1, JRE, JIM);
    job({18'h0, 9'b0_0010_0000, 9'b0_0111_0000}, {18'h0, 9'b1_0010_0000, 9'b1_0111_0000},
        ONE4, '0, 4'b0000, 4'b1111, 1'b0, '0, '0);
    for (int i = 0; i < 6; i++)
      job(36'({$urandom, $urandom}), 36'({$urandom, $urandom}), 36'({$urandom, $urandom}),
          36'({$urandom, $urandom}), 4'($urandom), 4'($urandom), 1'b0, '0, '0);
    drive(36'({$urandom, $urandom}), 36'({$urandom, $urandom}), ONE4, ONE4, 4'b0000, 4'b0000, 1'b0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    repeat (6) @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    drive(XV, XV, ONE4, '0, 4'b0000, 4'b1111, 1'b1, ERE, EIM);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_real", output_real, '0);
    check("abort_imag", output_imag, '0);
    check("abort_done", 36'(hadamard_done), '0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    job(XV, XV, ONE4, '0, 4'b0000, 4'b1111, 1'b1, ERE, EIM);
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    check("drain", 36'(sb.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
